// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction I / data D) arbiter in front of a
// single shared memory port. One transaction is outstanding at a time:
// IDLE grants a requester and captures its fields, REQ presents the held
// request to memory, RSP routes the memory response back to the owner.
//
// Parameters:
//   ADDR_W  address width (default 64)
//   DATA_W  data width (default 64); byte mask width is DATA_W/8
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req_*/i_rsp_*               instruction side (read-only requests)
//   d_req_*/d_rsp_*               data side (reads and masked writes)
//   m_req_*/m_rsp_*               shared memory port (one response per request)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous I/D requests alternate
//                       (D first after reset); otherwise D has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_rsp_valid,
  input  logic                d_rsp_ready,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_req_we,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wmask,
  input  logic                m_rsp_valid,
  output logic                m_rsp_ready,
  input  logic [DATA_W-1:0]   m_rsp_data
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  grant_i, grant_d;
  logic                  rsp_active;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t                last_owner_q;
`endif

  // Grant decision; only meaningful in IDLE and suppressed during reset so
  // that no ready is ever seen while rst is high.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i_req_valid && d_req_valid) begin
        grant_d = (last_owner_q == OWN_I);
        grant_i = !grant_d;
      end else begin
        grant_d = d_req_valid;
        grant_i = i_req_valid;
      end
`else
      grant_d = d_req_valid;
      grant_i = i_req_valid && !d_req_valid;
`endif
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d     = state_q;
    i_req_ready = grant_i;
    d_req_ready = grant_d;
    m_req_valid = !rst && (state_q == REQ);
    rsp_active  = !rst && (state_q == RSP);
    m_rsp_ready = 1'b0;
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    if (rsp_active) begin
      if (owner_q == OWN_D) begin
        m_rsp_ready = d_rsp_ready;
        d_rsp_valid = m_rsp_valid;
      end else begin
        m_rsp_ready = i_rsp_ready;
        i_rsp_valid = m_rsp_valid;
      end
    end
    unique case (state_q)
      IDLE:    if (grant_i || grant_d) state_d = REQ;
      REQ:     if (m_req_ready) state_d = RSP;
      RSP:     if (m_rsp_valid && m_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response data is simply forwarded; only the owner's valid qualifies it.
  assign i_rsp_data  = m_rsp_data;
  assign d_rsp_data  = m_rsp_data;
  assign m_req_we    = we_q;
  assign m_req_addr  = addr_q;
  assign m_req_wdata = wdata_q;
  assign m_req_wmask = wmask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_q <= OWN_D;
        we_q    <= d_req_we;
        addr_q  <= d_req_addr;
        wdata_q <= d_req_wdata;
        wmask_q <= d_req_wmask;
      end else if (grant_i) begin
        owner_q <= OWN_I;
        we_q    <= 1'b0;
        addr_q  <= i_req_addr;
        wdata_q <= '0;
        wmask_q <= '0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (grant_d)      last_owner_q <= OWN_D;
      else if (grant_i) last_owner_q <= OWN_I;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Directed sequences and
// a table of arbitration vectors, followed by randomized traffic checked
// against a transaction-level reference model with a bench-side memory.
// Build option ARB_ROUND_ROBIN_EN selects round-robin expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [63:0] i_req_addr;
  logic        i_rsp_valid, i_rsp_ready;
  logic [63:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [63:0] d_req_addr, d_req_wdata;
  logic [7:0]  d_req_wmask;
  logic        d_rsp_valid, d_rsp_ready;
  logic [63:0] d_rsp_data;
  logic        m_req_valid, m_req_ready, m_req_we;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_wmask;
  logic        m_rsp_valid, m_rsp_ready;
  logic [63:0] m_rsp_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [63:0] a);
    return {a[31:0], ~a[63:32]};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    i_req_valid = 0; d_req_valid = 0; d_req_we = 0;
    m_req_ready = 0; m_rsp_valid = 0; i_rsp_ready = 0; d_rsp_ready = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".i_req_ready"}, i_req_ready, 0);
    chk({tag, ".d_req_ready"}, d_req_ready, 0);
    chk({tag, ".m_req_valid"}, m_req_valid, 0);
    chk({tag, ".m_rsp_ready"}, m_rsp_ready, 0);
    chk({tag, ".i_rsp_valid"}, i_rsp_valid, 0);
    chk({tag, ".d_rsp_valid"}, d_rsp_valid, 0);
  endtask

  // Called just after a posedge; returns just after a posedge with rst low.
  task automatic do_reset();
    rst = 1;
    i_req_valid = 1; d_req_valid = 1; m_req_ready = 1; m_rsp_valid = 1;
    i_rsp_ready = 1; d_rsp_ready = 1;
    @(negedge clk); chk_quiet("rst0");
    @(posedge clk); #1;
    @(negedge clk); chk_quiet("rst1");
    chk("rst.m_req_addr", m_req_addr, 0);
    chk("rst.m_req_wdata", m_req_wdata, 0);
    chk("rst.m_req_wmask", m_req_wmask, 0);
    chk("rst.m_req_we", m_req_we, 0);
    @(posedge clk); #1;
    rst = 0; idle_inputs();
    @(negedge clk); chk_quiet("post_rst");
    @(posedge clk); #1;
  endtask

  // One complete transaction starting in IDLE, with memory stalls.
  task automatic txn(input string tag, input bit iv, input bit dv, input logic [63:0] iaddr,
                     input bit dwe, input logic [63:0] daddr, input logic [63:0] dwdata,
                     input logic [7:0] dmask, input int req_stall, input int rsp_stall,
                     input logic [63:0] rdata, input bit exp_d);
    logic        e_we;
    logic [63:0] e_addr;
    logic [7:0]  e_mask;
    i_req_valid = iv; i_req_addr = iaddr;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = daddr;
    d_req_wdata = dwdata; d_req_wmask = dmask;
    m_req_ready = 0; i_rsp_ready = 1; d_rsp_ready = 1;
    m_rsp_valid = 1; m_rsp_data = 64'hBAD0_BAD0;  // stray response in IDLE
    @(negedge clk);
    chk({tag, ".i_req_ready"}, i_req_ready, iv && !exp_d);
    chk({tag, ".d_req_ready"}, d_req_ready, exp_d);
    chk({tag, ".idle_m_req_valid"}, m_req_valid, 0);
    chk({tag, ".idle_m_rsp_ready"}, m_rsp_ready, 0);
    chk({tag, ".idle_rsp_valid"}, {i_rsp_valid, d_rsp_valid}, 0);
    e_we   = exp_d ? dwe : 1'b0;
    e_addr = exp_d ? daddr : iaddr;
    e_mask = exp_d ? dmask : 8'h00;
    @(posedge clk); #1;
    // Requesters keep asking with different fields; nothing may change.
    i_req_valid = 1; d_req_valid = 1; d_req_we = ~dwe;
    i_req_addr = rnd64(); d_req_addr = rnd64(); d_req_wdata = rnd64(); d_req_wmask = ~dmask;
    m_rsp_valid = 0;
    for (int k = 0; k <= req_stall; k++) begin
      m_req_ready = (k == req_stall);
      @(negedge clk);
      chk({tag, ".m_req_valid"}, m_req_valid, 1);
      chk({tag, ".m_req_we"}, m_req_we, e_we);
      chk({tag, ".m_req_addr"}, m_req_addr, e_addr);
      chk({tag, ".m_req_wmask"}, m_req_wmask, e_mask);
      if (exp_d) chk({tag, ".m_req_wdata"}, m_req_wdata, dwdata);
      chk({tag, ".req_readies"}, {i_req_ready, d_req_ready}, 0);
      chk({tag, ".req_rsp_valids"}, {i_rsp_valid, d_rsp_valid}, 0);
      @(posedge clk); #1;
    end
    m_req_ready = 0; m_rsp_valid = 1; m_rsp_data = rdata;
    for (int k = 0; k <= rsp_stall; k++) begin
      i_rsp_ready = exp_d ? 1'b1 : (k == rsp_stall);
      d_rsp_ready = exp_d ? (k == rsp_stall) : 1'b1;
      @(negedge clk);
      chk({tag, ".i_rsp_valid"}, i_rsp_valid, !exp_d);
      chk({tag, ".d_rsp_valid"}, d_rsp_valid, exp_d);
      chk({tag, ".rsp_data"}, exp_d ? d_rsp_data : i_rsp_data, rdata);
      chk({tag, ".m_rsp_ready"}, m_rsp_ready, k == rsp_stall);
      chk({tag, ".rsp_readies"}, {i_req_ready, d_req_ready, m_req_valid}, 0);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk); chk_quiet({tag, ".after"});
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          iv, dv;
    logic [63:0] iaddr;
    bit          dwe;
    logic [63:0] daddr, dwdata;
    logic [7:0]  dmask;
    int          req_stall, rsp_stall;
    logic [63:0] rdata;
    bit          exp_d_fix, exp_d_rr;
  } vec_t;

  vec_t tbl[7];

  // Randomized-phase reference model (one outstanding transaction).
  bit          busy, sent, own_d, last_d, win_d, exp_i, exp_dg;
  logic        r_we;
  logic [63:0] r_addr, r_wdata;
  logic [7:0]  r_mask;
  int          wait_n;

  initial begin
    rst = 1; idle_inputs();
    i_req_addr = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wmask = 0; m_rsp_data = 0;
    do_reset();

    txn("i_read", 1, 0, 64'h100, 0, 64'h0, 64'h0, 8'h00, 0, 0, 64'hDEAD, 0);
    txn("d_write", 0, 1, 64'h0, 1, 64'h200, 64'h1122, 8'h0F, 3, 0, 64'h0, 1);
    txn("rsp_stall", 1, 0, 64'h340, 0, 64'h0, 64'h0, 8'h00, 0, 5, 64'h5A5A_0001, 0);

    do_reset();
    tbl[0] = '{1, 1, 64'h1000, 0, 64'h2000, 64'h0, 8'h00, 0, 0, 64'hA0, 1, 1};
    tbl[1] = '{1, 1, 64'h1008, 0, 64'h2008, 64'h0, 8'h00, 1, 0, 64'hA1, 1, 0};
    tbl[2] = '{1, 1, 64'h1010, 1, 64'h2010, 64'hFEED, 8'hF0, 0, 1, 64'hA2, 1, 1};
    tbl[3] = '{1, 1, 64'h1018, 0, 64'h2018, 64'h0, 8'h00, 0, 0, 64'hA3, 1, 0};
    tbl[4] = '{1, 0, 64'h1020, 0, 64'h0, 64'h0, 8'h00, 2, 0, 64'hA4, 0, 0};
    tbl[5] = '{0, 1, 64'h0, 1, 64'h2028, 64'hCAFE, 8'h81, 0, 2, 64'hA5, 1, 1};
    tbl[6] = '{1, 1, 64'h1030, 0, 64'h2030, 64'h0, 8'h00, 0, 0, 64'hA6, 1, 0};
    foreach (tbl[n]) begin
`ifdef ARB_ROUND_ROBIN_EN
      txn($sformatf("tbl%0d", n), tbl[n].iv, tbl[n].dv, tbl[n].iaddr, tbl[n].dwe, tbl[n].daddr,
          tbl[n].dwdata, tbl[n].dmask, tbl[n].req_stall, tbl[n].rsp_stall, tbl[n].rdata,
          tbl[n].exp_d_rr);
`else
      txn($sformatf("tbl%0d", n), tbl[n].iv, tbl[n].dv, tbl[n].iaddr, tbl[n].dwe, tbl[n].daddr,
          tbl[n].dwdata, tbl[n].dmask, tbl[n].req_stall, tbl[n].rsp_stall, tbl[n].rdata,
          tbl[n].exp_d_fix);
`endif
    end

    // Reset while a D read is waiting in REQ.
    d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h4440;
    @(negedge clk); chk("abort.d_req_ready", d_req_ready, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk); chk("abort.m_req_valid", m_req_valid, 1);
    @(posedge clk); #1;
    do_reset();
    txn("after_abort", 1, 0, 64'h5550, 0, 64'h0, 64'h0, 8'h00, 0, 0, 64'h7777, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    busy = 0; sent = 0; own_d = 0; last_d = 0; wait_n = 0;
    r_we = 0; r_addr = 0; r_wdata = 0; r_mask = 0;
    for (int c = 0; c < 3000; c++) begin
      i_req_valid = ($urandom_range(0, 2) != 0);
      d_req_valid = ($urandom_range(0, 2) != 0);
      i_req_addr = rnd64(); d_req_addr = rnd64(); d_req_wdata = rnd64();
      d_req_we = $urandom_range(0, 1); d_req_wmask = 8'($urandom);
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      m_req_ready = $urandom_range(0, 1);
      if (busy && sent && wait_n == 0) begin
        m_rsp_valid = 1; m_rsp_data = r_we ? 64'h0 : data_of(r_addr);
      end else if (!busy) begin
        m_rsp_valid = $urandom_range(0, 1); m_rsp_data = rnd64();
      end else begin
        m_rsp_valid = 0; m_rsp_data = rnd64();
      end
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      win_d = d_req_valid && (!i_req_valid || !last_d);
`else
      win_d = d_req_valid;
`endif
      exp_dg = !busy && win_d;
      exp_i  = !busy && i_req_valid && !win_d;
      chk("rnd.i_req_ready", i_req_ready, exp_i);
      chk("rnd.d_req_ready", d_req_ready, exp_dg);
      chk("rnd.m_req_valid", m_req_valid, busy && !sent);
      if (busy && !sent) begin
        chk("rnd.m_req_we", m_req_we, r_we);
        chk("rnd.m_req_addr", m_req_addr, r_addr);
        chk("rnd.m_req_wmask", m_req_wmask, r_mask);
        if (own_d) chk("rnd.m_req_wdata", m_req_wdata, r_wdata);
      end
      chk("rnd.m_rsp_ready", m_rsp_ready, busy && sent && (own_d ? d_rsp_ready : i_rsp_ready));
      chk("rnd.i_rsp_valid", i_rsp_valid, busy && sent && !own_d && m_rsp_valid);
      chk("rnd.d_rsp_valid", d_rsp_valid, busy && sent && own_d && m_rsp_valid);
      if (busy && sent && m_rsp_valid && !r_we)
        chk("rnd.rsp_data", own_d ? d_rsp_data : i_rsp_data, data_of(r_addr));
      if (exp_dg || exp_i) begin
        busy = 1; sent = 0; own_d = exp_dg; last_d = exp_dg;
        r_we    = exp_dg ? d_req_we : 1'b0;
        r_addr  = exp_dg ? d_req_addr : i_req_addr;
        r_wdata = d_req_wdata;
        r_mask  = exp_dg ? d_req_wmask : 8'h00;
      end else if (busy && !sent) begin
        if (m_req_ready) begin sent = 1; wait_n = $urandom_range(0, 2); end
      end else if (busy && sent) begin
        if (m_rsp_valid && (own_d ? d_rsp_ready : i_rsp_ready)) busy = 0;
        else if (wait_n > 0) wait_n--;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, the address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, the data width; the mask width is DATA_W/8.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 i_req_valid  in  1  instruction-side read request.
REQ-006 i_req_ready  out  1  instruction request accepted this cycle.
REQ-007 i_req_addr  in  ADDR_W  instruction fetch address.
REQ-008 i_rsp_valid  out  1  instruction read data valid.
REQ-009 i_rsp_ready  in  1  instruction side accepts read data.
REQ-010 i_rsp_data  out  DATA_W  instruction read data.
REQ-011 d_req_valid  in  1  data-side request.
REQ-012 d_req_ready  out  1  data request accepted this cycle.
REQ-013 d_req_we  in  1  data request type: 1 is write, 0 is read.
REQ-014 d_req_addr  in  ADDR_W  data address.
REQ-015 d_req_wdata  in  DATA_W  write data.
REQ-016 d_req_wmask  in  DATA_W/8  byte write mask.
REQ-017 d_rsp_valid  out  1  data response (read data or write acknowledge) valid.
REQ-018 d_rsp_ready  in  1  data side accepts the response.
REQ-019 d_rsp_data  out  DATA_W  data read data.
REQ-020 m_req_valid / m_req_ready  out / in  1 / 1  shared memory request handshake.
REQ-021 m_req_we, m_req_addr, m_req_wdata, m_req_wmask  out  1, ADDR_W, DATA_W, DATA_W/8  held request fields.
REQ-022 m_rsp_valid / m_rsp_ready  in / out  1 / 1  memory response handshake; the memory returns one response per request, including writes.
REQ-023 m_rsp_data  in  DATA_W  memory read data.

Function
REQ-024 The FSM SHALL have three states: IDLE, REQ and RSP, plus an owner register holding I or D.
REQ-025 In IDLE, when any request valid is high, the block SHALL grant exactly one requester, assert that requester's req_ready in the same cycle, capture its fields into holding registers, and move to REQ.
REQ-026 An instruction grant SHALL hold we=0 and wmask=0.
REQ-027 In REQ, m_req_valid SHALL be 1 and the held fields SHALL be stable until m_req_ready; on m_req_ready the FSM SHALL move to RSP.
REQ-028 In RSP, the owner's rsp_valid SHALL equal m_rsp_valid, the owner's rsp_data SHALL equal m_rsp_data, and m_rsp_ready SHALL equal the owner's rsp_ready; on that handshake the FSM SHALL return to IDLE.
REQ-029 The non-owner's rsp_valid SHALL be 0 at all times, and both req_ready outputs SHALL be 0 outside IDLE.
REQ-030 At most one transaction SHALL be outstanding; the earliest response handshake is 2 cycles after acceptance.
REQ-031 Requester inputs changing or valid dropping after acceptance SHALL have no effect on the held transaction.
REQ-032 In IDLE, m_req_valid and m_rsp_ready SHALL be 0; a stray m_rsp_valid SHALL be ignored.

Reset
REQ-033 Reset SHALL set the state to IDLE, the owner to I, last_owner to I, and the holding registers to 0; all valid/ready outputs SHALL be 0 during reset.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no response delivered; the memory is reset by the same rst.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, when both requesters are valid in IDLE, the requester not recorded in last_owner SHALL win; last_owner updates on every grant, so D wins first after reset.
REQ-036 Without ARB_ROUND_ROBIN_EN, D SHALL always win over I (fixed priority) and last_owner SHALL not exist.

Verification
REQ-037 After reset, I read 0x100 with m_req_ready=1, and memory returns 0xDEAD next cycle -> i_rsp_valid with 0xDEAD on the 2nd cycle after acceptance; d_rsp_valid stays 0.
REQ-038 D write to 0x200, wdata 0x1122, mask 0x0F, with m_req_ready held low for 3 cycles -> m_req fields stable for all 4 REQ cycles; the write acknowledge reaches d_rsp_valid.
REQ-039 I and D valid in the same IDLE cycle, repeated 4 times -> fixed priority: D, D, D, D; with ARB_ROUND_ROBIN_EN: D, I, D, I.
REQ-040 i_rsp_ready low for 5 cycles during RSP -> m_rsp_ready low, FSM stays in RSP, no new grant until the handshake completes.
REQ-041 rst pulsed in REQ after a D read is accepted -> next cycle IDLE, all valids 0, a following I request is granted normally.
